iq_gain_out_fifo: RTL and testbench

- Downstream stage of rrc_fir. Consumes the filtered I/Q stream (real_out, imag_out, out_valid) and applies a programmable fixed-point gain with rounding and saturation.
- Buffers scaled samples in a small FIFO and delivers them to the DAC interface over a valid/ready handshake.
- rrc_fir has no backpressure, so this block absorbs the rate jitter. It reports overflow and underrun with sticky flags.

---
 rtl/iq_out_pkg.sv | 37 +++
 rtl/iq_sync_fifo.sv | 65 ++++++
 rtl/iq_gain_out_fifo.sv | 174 +++++++++++++++++
 tb/tb_iq_gain_out_fifo.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_out_pkg.sv
// Shared constants, FSM state type and the round/saturate helper for iq_gain_out_fifo.
package iq_out_pkg;

    localparam int unsigned DATA_W_DEF    = 16;
    localparam int unsigned GAIN_W_DEF    = 16;
    localparam int unsigned GAIN_FRAC_DEF = 14;
    localparam int unsigned GAIN_UNITY    = 16384;
    localparam int unsigned CALC_W        = 64;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } out_state_e;

    // Round half up, arithmetic shift by frac, clamp to a signed dw-bit range.
    function automatic logic signed [CALC_W-1:0] sat_round(
        input logic signed [CALC_W-1:0] product,
        input int unsigned              frac,
        input int unsigned              dw
    );
        logic signed [CALC_W-1:0] one;
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        logic signed [CALC_W-1:0] y;
        one = 64'sd1;
        y   = (product + (one <<< (frac - 1))) >>> frac;
        hi  = (one <<< (dw - 1)) - one;
        lo  = -(one <<< (dw - 1));
        if (y > hi) begin
            y = hi;
        end else if (y < lo) begin
            y = lo;
        end
        return y;
    endfunction

endpackage

// File: rtl/iq_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head and registered occupancy.
module iq_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_c,
    output logic                     full_c,
    output logic                     empty_c,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (wr_en_i) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (rd_en_i) begin
            rptr_d = rptr_q + AW'(1);
        end
        if (wr_en_i && !rd_en_i) begin
            level_d = level_q + LW'(1);
        end else if (!wr_en_i && rd_en_i) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wptr_q] <= wr_data_i;
        end
    end

    assign rd_data_c = mem_q[rptr_q];
    assign full_c    = (level_q == LW'(DEPTH));
    assign empty_c   = (level_q == '0);
    assign level_o   = level_q;

endmodule

// File: rtl/iq_gain_out_fifo.sv
// I/Q gain stage with rounding/saturation, elastic FIFO and DAC valid/ready output.
// Build option: define UNDERRUN_ZERO_EN to present zero-valued valid pairs while refilling.
import iq_out_pkg::*;

module iq_gain_out_fifo #(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned GAIN_W      = GAIN_W_DEF,
    parameter int unsigned GAIN_FRAC   = GAIN_FRAC_DEF,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned START_LEVEL = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [DATA_W-1:0]  in_real,
    input  logic signed [DATA_W-1:0]  in_imag,
    input  logic                      in_valid,
    input  logic        [GAIN_W-1:0]  gain,
    input  logic                      clr_flags,
    output logic signed [DATA_W-1:0]  out_i,
    output logic signed [DATA_W-1:0]  out_q,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
    output logic                      underrun
);

    localparam int unsigned PROD_W = DATA_W + GAIN_W + 1;
    localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;

    logic signed [PROD_W-1:0] prod_i_q, prod_q_q, prod_i_d, prod_q_d;
    logic                     s1_valid_q;
    logic signed [DATA_W-1:0] sat_i_q, sat_q_q, sat_i_d, sat_q_d;
    logic                     s2_valid_q;

    always_comb begin
        prod_i_d = PROD_W'(in_real) * PROD_W'($signed({1'b0, gain}));
        prod_q_d = PROD_W'(in_imag) * PROD_W'($signed({1'b0, gain}));
        sat_i_d  = DATA_W'(sat_round(CALC_W'(prod_i_q), GAIN_FRAC, DATA_W));
        sat_q_d  = DATA_W'(sat_round(CALC_W'(prod_q_q), GAIN_FRAC, DATA_W));
    end

    // Two-stage scaling pipeline; never stalls since the source cannot be throttled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_i_q   <= '0;
            prod_q_q   <= '0;
            s1_valid_q <= 1'b0;
            sat_i_q    <= '0;
            sat_q_q    <= '0;
            s2_valid_q <= 1'b0;
        end else begin
            prod_i_q   <= prod_i_d;
            prod_q_q   <= prod_q_d;
            s1_valid_q <= in_valid;
            sat_i_q    <= sat_i_d;
            sat_q_q    <= sat_q_d;
            s2_valid_q <= s1_valid_q;
        end
    end

    logic                    wr_en_c, rd_en_c;
    logic [2*DATA_W-1:0]     head_c;
    logic                    full_c, empty_c;
    logic [LVL_W-1:0]        fifo_level;
    logic signed [DATA_W-1:0] head_i, head_q;

    iq_sync_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .wr_en_i   (wr_en_c),
        .wr_data_i ({sat_i_q, sat_q_q}),
        .rd_en_i   (rd_en_c),
        .rd_data_c (head_c),
        .full_c    (full_c),
        .empty_c   (empty_c),
        .level_o   (fifo_level)
    );

    assign head_i = head_c[2*DATA_W-1:DATA_W];
    assign head_q = head_c[DATA_W-1:0];

    out_state_e               state_q, state_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] out_i_q, out_i_d;
    logic signed [DATA_W-1:0] out_q_q, out_q_d;
    logic                     ovf_q, ovf_d;
    logic                     und_q, und_d;
    logic                     ran_q, ran_d;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_i_d     = out_i_q;
        out_q_d     = out_q_q;
        ovf_d       = clr_flags ? 1'b0 : ovf_q;
        und_d       = clr_flags ? 1'b0 : und_q;
        ran_d       = ran_q;
        rd_en_c     = 1'b0;
        unique case (state_q)
            FILL: begin
                out_valid_d = 1'b0;
`ifdef UNDERRUN_ZERO_EN
                if (ran_q) begin
                    out_valid_d = 1'b1;
                    out_i_d     = '0;
                    out_q_d     = '0;
                end
`endif
                if (fifo_level >= LVL_W'(START_LEVEL)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                ran_d = 1'b1;
                if (!empty_c && (!out_valid_q || out_ready)) begin
                    rd_en_c     = 1'b1;
                    out_valid_d = 1'b1;
                    out_i_d     = head_i;
                    out_q_d     = head_q;
                end else if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end else if (!out_valid_q && out_ready) begin
                    // Consumer starved with the output register already drained.
                    und_d   = 1'b1;
                    state_d = FILL;
`ifdef UNDERRUN_ZERO_EN
                    out_valid_d = 1'b1;
                    out_i_d     = '0;
                    out_q_d     = '0;
`endif
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
        wr_en_c = s2_valid_q && (!full_c || rd_en_c);
        if (s2_valid_q && !wr_en_c) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FILL;
            out_valid_q <= 1'b0;
            out_i_q     <= '0;
            out_q_q     <= '0;
            ovf_q       <= 1'b0;
            und_q       <= 1'b0;
            ran_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_i_q     <= out_i_d;
            out_q_q     <= out_q_d;
            ovf_q       <= ovf_d;
            und_q       <= und_d;
            ran_q       <= ran_d;
        end
    end

    assign out_i     = out_i_q;
    assign out_q     = out_q_q;
    assign out_valid = out_valid_q;
    assign level     = fifo_level;
    assign overflow  = ovf_q;
    assign underrun  = und_q;

endmodule

// File: tb/tb_iq_gain_out_fifo.sv
// Randomised bench for iq_gain_out_fifo against a queue-based reference model.
import iq_out_pkg::*;

module tb_iq_gain_out_fifo;

    localparam int unsigned DW    = 16;
    localparam int unsigned GW    = 16;
    localparam int unsigned GF    = 14;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned START = 8;

    logic                 clk;
    logic                 rst;
    logic signed [DW-1:0] in_real, in_imag;
    logic                 in_valid;
    logic [GW-1:0]        gain;
    logic                 clr_flags;
    logic signed [DW-1:0] out_i, out_q;
    logic                 out_valid;
    logic                 out_ready;
    logic [$clog2(DEPTH):0] level;
    logic                 overflow, underrun;

    iq_gain_out_fifo #(
        .DATA_W      (DW),
        .GAIN_W      (GW),
        .GAIN_FRAC   (GF),
        .DEPTH       (DEPTH),
        .START_LEVEL (START)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .in_valid  (in_valid),
        .gain      (gain),
        .clr_flags (clr_flags),
        .out_i     (out_i),
        .out_q     (out_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow),
        .underrun  (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic signed [63:0] got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: samples travel through a 2-slot delay, then a queue, then the output slot.
    typedef struct {
        bit v;
        int i;
        int q;
    } smp_t;

    smp_t dl0, dl1;
    smp_t fq[$];
    bit   m_valid;
    int   m_i, m_q;
    bit   m_run;
    bit   m_ovf, m_und;

    function automatic int scale(input int x, input int g);
        longint num, quo;
        num = longint'(x) * longint'(g) + longint'(GAIN_UNITY / 2);
        quo = num / longint'(GAIN_UNITY);
        if ((num % longint'(GAIN_UNITY) != 0) && (num < 0)) quo = quo - 1;
        if (quo > 32767) quo = 32767;
        if (quo < -32768) quo = -32768;
        return int'(quo);
    endfunction

    task automatic model_reset();
        dl0 = '{0, 0, 0};
        dl1 = '{0, 0, 0};
        fq.delete();
        m_valid = 0; m_i = 0; m_q = 0;
        m_run = 0; m_ovf = 0; m_und = 0;
    endtask

    task automatic model_step();
        int   lvl;
        bit   rd, und_ev, ovf_ev;
        smp_t head;
        if (!rst) begin
            model_reset();
        end else begin
            lvl    = fq.size();
            head   = '{0, 0, 0};
            rd     = m_run && (lvl > 0) && (!m_valid || out_ready);
            und_ev = m_run && out_ready && !m_valid && (lvl == 0);
            ovf_ev = dl1.v && (lvl == int'(DEPTH)) && !rd;
            if (rd) head = fq.pop_front();
            if (dl1.v && !ovf_ev) fq.push_back(dl1);
            if (rd) begin
                m_valid = 1; m_i = head.i; m_q = head.q;
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
            if (!m_run && lvl >= int'(START)) m_run = 1;
            else if (und_ev) m_run = 0;
            m_ovf = (clr_flags ? 1'b0 : m_ovf) | ovf_ev;
            m_und = (clr_flags ? 1'b0 : m_und) | und_ev;
            dl1 = dl0;
            dl0 = '{in_valid, scale(int'(in_real), int'(gain)), scale(int'(in_imag), int'(gain))};
        end
    endtask

    task automatic compare_all();
        check_val("out_valid", out_valid, longint'(m_valid));
        if (m_valid) begin
            check_val("out_i", out_i, longint'(m_i));
            check_val("out_q", out_q, longint'(m_q));
        end
        check_val("level", level, longint'(fq.size()));
        check_val("overflow", overflow, longint'(m_ovf));
        check_val("underrun", underrun, longint'(m_und));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic push(input int i, input int q);
        in_valid = 1'b1;
        in_real  = DW'(i);
        in_imag  = DW'(q);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int rv[8];
        int vp, rp;
        bit reached;
        rv = '{3, -3, 1, -1, 5, -5, 7, 0};
        rst = 1'b0; in_real = '0; in_imag = '0; in_valid = 1'b0;
        gain = GW'(GAIN_UNITY); clr_flags = 1'b0; out_ready = 1'b1;
        model_reset();
        repeat (3) tick();
        rst = 1'b1;

        // unity gain, then drain into underrun
        for (int k = 0; k < 8; k++) push(1000 + k, -1000 - k);
        repeat (20) tick();

        // saturation
        gain = GW'(32767);
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) push(30000, -30000);
            else push(-30000, 30000);
        end
        repeat (20) tick();

        // rounding at half gain
        gain = GW'(8192);
        for (int k = 0; k < 8; k++) push(rv[k], -rv[k]);
        repeat (20) tick();

        // overflow with a stalled consumer, then clear and drain
        gain = GW'(GAIN_UNITY);
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) push(k, -k);
        repeat (4) tick();
        for (int k = 0; k < 17; k++) push(100 + k, -100 - k);
        repeat (3) tick();
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        out_ready = 1'b1;
        repeat (40) tick();

        // randomised traffic
        vp = 50; rp = 70;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) begin
                vp = int'($urandom_range(20, 90));
                rp = int'($urandom_range(20, 100));
            end
            case ($urandom_range(0, 15))
                0: gain = GW'(GAIN_UNITY);
                1: gain = GW'(8192);
                2: gain = GW'(32767);
                3: gain = GW'(65535);
                4: gain = '0;
                default: ;
            endcase
            if ($urandom_range(0, 31) == 0) gain = GW'($urandom);
            in_valid  = ($urandom_range(0, 99) < vp);
            in_real   = DW'($urandom);
            in_imag   = DW'($urandom);
            out_ready = ($urandom_range(0, 99) < rp);
            clr_flags = ($urandom_range(0, 63) == 0);
            tick();
        end
        in_valid = 1'b0; clr_flags = 1'b0;
        out_ready = 1'b1;
        repeat (30) tick();

        // asynchronous reset mid-stream at level 5 with a pending output
        gain = GW'(GAIN_UNITY);
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) push(200 + k, -200 - k);
        repeat (4) tick();
        out_ready = 1'b1;
        reached = 0;
        for (int c = 0; c < 30 && !reached; c++) begin
            if (fq.size() == 5 && m_valid) reached = 1;
            else tick();
        end
        check_val("mid_reset_setup_level", level, 5);
        #2 rst = 1'b0;
        #1;
        check_val("async_rst_valid", out_valid, 0);
        check_val("async_rst_level", level, 0);
        check_val("async_rst_ovf", overflow, 0);
        check_val("async_rst_und", underrun, 0);
        model_reset();
        @(negedge clk);
        compare_all();
        repeat (2) tick();
        rst = 1'b1;
        for (int k = 0; k < 8; k++) push(300 + k, -300 - k);
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
